fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PCINIT, default 64'h0000_0000_8000_0000, the PC fetched first after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireq  output  ibus_req_t (valid 1, addr 64)  instruction fetch request.
REQ-005 SHALL have port iresp  input  ibus_resp_t (addr_ok 1, data_ok 1, data 32)  fetch response; data valid only when data_ok=1.
REQ-006 SHALL have port redirect_valid  input  1  one-cycle pulse: the next PC is redirect_pc (taken branch/jump).
REQ-007 SHALL have port redirect_pc  input  u64  redirect target, sampled only when redirect_valid=1.
REQ-008 SHALL have port stall  input  1  decode cannot accept this cycle.
REQ-009 SHALL have ports out_valid (1), out_pc (u64), out_raw_instr (u32)  outputs  registered fetched instruction to decode.

Function
REQ-010 SHALL implement a three-state FSM: FETCH, HOLD, DISCARD; internal regs pc (u64) and pending_pc (u64).
REQ-011 In FETCH and DISCARD, SHALL drive ireq.valid=1 and ireq.addr=pc; in HOLD, ireq.valid=0.
REQ-012 Once ireq.valid rises, SHALL hold ireq.valid and ireq.addr stable until the cycle with iresp.data_ok=1; a transaction completes on data_ok, and addr_ok is ignored.
REQ-013 FETCH, data_ok=1, redirect_valid=0: SHALL register out_valid<=1, out_pc<=pc, out_raw_instr<=iresp.data, pc<=pc+4, and go to HOLD.
REQ-014 FETCH, data_ok=1, redirect_valid=1: SHALL drop the data, set pc<=redirect_pc, stay in FETCH, and keep out_valid at 0.
REQ-015 FETCH, data_ok=0, redirect_valid=1: SHALL set pending_pc<=redirect_pc and go to DISCARD, keeping ireq.addr at the old pc.
REQ-016 DISCARD, data_ok=0, redirect_valid=1: SHALL overwrite pending_pc with redirect_pc (latest redirect wins).
REQ-017 DISCARD, data_ok=1: SHALL drop the data, set pc<=(redirect_valid ? redirect_pc : pending_pc), and go to FETCH; out_valid stays 0.
REQ-018 HOLD: SHALL keep out_valid=1 and out_pc/out_raw_instr stable while stall=1 and redirect_valid=0.
REQ-019 HOLD, stall=0, redirect_valid=0: SHALL set out_valid<=0 and go to FETCH; the instruction counts as consumed in this cycle.
REQ-020 HOLD, redirect_valid=1: SHALL set out_valid<=0 and pc<=redirect_pc, then go to FETCH; redirect has priority over stall, and the held instruction is squashed.
REQ-021 SHALL compute pc+4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-022 SHALL pass redirect_pc unchanged; misalignment checking is outside this block.
REQ-023 Fetch-to-output latency SHALL be 1 cycle after data_ok; at most one instruction is outstanding at any time.

Reset
REQ-024 While reset=1, SHALL immediately force state=FETCH, pc=PCINIT, pending_pc=0, out_valid=0, out_pc=0, out_raw_instr=0 and ireq.valid=0.
REQ-025 On the first clk edge after reset deasserts, SHALL present ireq.valid=1 with addr=PCINIT.
REQ-026 Reset asserted mid-transaction SHALL abandon that transaction; a data_ok arriving during or after reset for the abandoned request is the bus's responsibility and is not filtered.

Structure
REQ-027 ibus_req_t, ibus_resp_t, u64 and u32 SHALL come from the shared package common; the FSM state enum is local to the module.
REQ-028 SHALL be a single module with the next-PC selection inline; no sub-module.

Verification
REQ-029 Reset, then data_ok every 2nd cycle with stall=0: ireq.addr 8000_0000, 8000_0004, 8000_0008; out_pc follows with one-cycle latency.
REQ-030 Redirect to 8000_1000 in FETCH with data_ok delayed 3 cycles: addr stays 8000_0000 until data_ok; no out_valid; next ireq.addr=8000_1000.
REQ-031 Two redirects in DISCARD (8000_2000, then 8000_3000): after data_ok, ireq.addr=8000_3000.
REQ-032 HOLD with stall=1 for 5 cycles, data 0x00000013: out_valid, out_pc and out_raw_instr stay constant; ireq.valid=0; after stall drops, out_valid=0 next cycle and fetch of pc+4 begins.
REQ-033 HOLD with stall=1 and redirect to 8000_4000: out_valid=0 next cycle, ireq.addr=8000_4000; the squashed instruction never appears again.
REQ-034 Reset asserted mid-request: outputs clear asynchronously without a clock edge; after release, ireq.addr=PCINIT.

Source files
------------

// File: rtl/common.sv
// Shared scalar and instruction-bus types used by the front-end blocks.
package common;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, redirect handling
// with squash of in-flight responses, and a registered one-entry output to decode.
module fetch_ctrl
  import common::*;
#(
  parameter u64 PCINIT = 64'h0000_0000_8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  output ibus_req_t  ireq,
  input  ibus_resp_t iresp,
  input  logic       redirect_valid,
  input  u64         redirect_pc,
  input  logic       stall,
  output logic       out_valid,
  output u64         out_pc,
  output u32         out_raw_instr
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0] state;
  u64         pc;
  u64         pending_pc;
  u64         pc_inc;
  logic       started;
  logic       unused_bits;

  // started keeps the request low while reset is held and for the reset-release cycle
  assign pc_inc      = pc + 64'd4;
  assign ireq.valid  = started && (state != HOLD);
  assign ireq.addr   = pc;
  assign unused_bits = iresp.addr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= PCINIT;
      pending_pc    <= '0;
      started       <= 1'b0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_raw_instr <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH: begin
          if (!started) begin
            // No request is outstanding yet, so a redirect just retargets the first fetch
            if (redirect_valid) pc <= redirect_pc;
          end else if (iresp.data_ok) begin
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else begin
              out_valid     <= 1'b1;
              out_pc        <= pc;
              out_raw_instr <= iresp.data;
              pc            <= pc_inc;
              state         <= HOLD;
            end
          end else if (redirect_valid) begin
            pending_pc <= redirect_pc;
            state      <= DISCARD;
          end
        end
        DISCARD: begin
          if (iresp.data_ok) begin
            pc    <= redirect_valid ? redirect_pc : pending_pc;
            state <= FETCH;
          end else if (redirect_valid) begin
            pending_pc <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            pc        <= redirect_pc;
            state     <= FETCH;
          end else if (!stall) begin
            out_valid <= 1'b0;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized bus/redirect/stall traffic checked every cycle against a transaction model.
module tb_fetch_ctrl;
  import common::*;

  localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       redirect_valid;
  u64         redirect_pc;
  logic       stall;
  logic       out_valid;
  u64         out_pc;
  u32         out_raw_instr;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  // Transaction-level model: a fetch is either in flight, squashed, or delivered and held
  bit          m_started;
  bit          m_held;
  bit          m_squash;
  logic [63:0] m_pc;
  logic [63:0] m_target;
  logic [63:0] m_opc;
  logic [31:0] m_oinstr;

  fetch_ctrl #(.PCINIT(PCINIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_raw_instr  (out_raw_instr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_held    = 0;
    m_squash  = 0;
    m_pc      = PCINIT;
    m_target  = '0;
    m_opc     = '0;
    m_oinstr  = '0;
  endtask

  function automatic bit model_req();
    return m_started && !m_held;
  endfunction

  task automatic model_step(input bit rv, input logic [63:0] rpc, input bit st,
                            input bit dok, input logic [31:0] d);
    if (!m_started) begin
      if (rv) m_pc = rpc;
      m_started = 1;
    end else if (m_held) begin
      if (rv || !st) begin
        if (!rv) $display("xfer pc=%h instr=%h", m_opc, m_oinstr);
        else     $display("squash pc=%h redirect=%h", m_opc, rpc);
        m_held = 0;
      end
      if (rv) m_pc = rpc;
    end else if (dok) begin
      if (m_squash) begin
        m_pc     = rv ? rpc : m_target;
        m_squash = 0;
      end else if (rv) begin
        m_pc = rpc;
      end else begin
        m_held   = 1;
        m_opc    = m_pc;
        m_oinstr = d;
        m_pc     = m_pc + 64'd4;
      end
    end else if (rv) begin
      m_squash = 1;
      m_target = rpc;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land just after the next negedge
  task automatic cyc(input bit rv, input logic [63:0] rpc, input bit st,
                     input bit dok, input logic [31:0] d);
    redirect_valid = rv;
    redirect_pc    = rv ? rpc : {$urandom, $urandom};
    stall          = st;
    iresp.data_ok  = dok;
    iresp.data     = dok ? d : $urandom;
    iresp.addr_ok  = 1'($urandom);
    model_step(rv, rpc, st, dok, d);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("ireq_valid", 64'(ireq.valid), 64'(model_req()));
      if (model_req()) chk("ireq_addr", ireq.addr, m_pc);
      chk("out_valid", 64'(out_valid), 64'(m_held));
      if (m_held) begin
        chk("out_pc", out_pc, m_opc);
        chk("out_raw_instr", 64'(out_raw_instr), 64'(m_oinstr));
      end
    end
  end

  initial begin
    reset          = 1;
    redirect_valid = 0;
    redirect_pc    = '0;
    stall          = 0;
    iresp          = '0;
    model_reset();
    check_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    #1;
    reset = 0;

    // Sequential fetch, data_ok every second cycle
    cyc(0, 0, 0, 0, 0);
    chk("seq_addr0", ireq.addr, 64'h8000_0000);
    chk("seq_valid0", 64'(ireq.valid), 64'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h1111_1111);
    chk("seq_out_pc0", out_pc, 64'h8000_0000);
    chk("seq_out_v0", 64'(out_valid), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("seq_addr1", ireq.addr, 64'h8000_0004);
    cyc(0, 0, 0, 1, 32'h2222_2222);
    chk("seq_out_pc1", out_pc, 64'h8000_0004);
    cyc(0, 0, 0, 0, 0);
    chk("seq_addr2", ireq.addr, 64'h8000_0008);

    // Redirect while the request waits; address must not move until data_ok
    cyc(1, 64'h8000_1000, 0, 0, 0);
    chk("disc_addr_hold", ireq.addr, 64'h8000_0008);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("disc_addr_hold2", ireq.addr, 64'h8000_0008);
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("disc_out_v", 64'(out_valid), 64'd0);
    chk("disc_new_addr", ireq.addr, 64'h8000_1000);

    // Latest redirect in DISCARD wins
    cyc(1, 64'h8000_2000, 0, 0, 0);
    cyc(1, 64'h8000_3000, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hBAD0_BAD0);
    chk("latest_redirect", ireq.addr, 64'h8000_3000);

    // Stalled hold keeps output stable and the bus idle
    cyc(0, 0, 1, 1, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_pc", out_pc, 64'h8000_3000);
      chk("hold_instr", 64'(out_raw_instr), 64'h13);
      chk("hold_req", 64'(ireq.valid), 64'd0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("release_v", 64'(out_valid), 64'd0);
    chk("release_addr", ireq.addr, 64'h8000_3004);

    // Redirect squashes a stalled held instruction
    cyc(0, 0, 1, 1, 32'h0000_0093);
    cyc(1, 64'h8000_4000, 1, 0, 0);
    chk("squash_v", 64'(out_valid), 64'd0);
    chk("squash_addr", ireq.addr, 64'h8000_4000);
    cyc(0, 0, 0, 1, 32'h0000_0113);
    chk("squash_next_pc", out_pc, 64'h8000_4000);

    // PC increment wraps at the top of the address space
    cyc(0, 0, 0, 0, 0);
    cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 32'h1);
    chk("wrap_top_addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 1, 32'h0000_0213);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_addr", ireq.addr, 64'h0);

    // Asynchronous reset while an instruction is held
    cyc(0, 0, 1, 1, 32'h0000_0313);
    chk("pre_rst_v", 64'(out_valid), 64'd1);
    #2;
    reset = 1;
    #1;
    chk("async_out_v", 64'(out_valid), 64'd0);
    chk("async_req_v", 64'(ireq.valid), 64'd0);
    chk("async_out_pc", out_pc, 64'd0);
    chk("async_instr", 64'(out_raw_instr), 64'd0);
    model_reset();
    @(negedge clk);
    #1;
    reset = 0;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_addr", ireq.addr, PCINIT);
    chk("post_rst_valid", 64'(ireq.valid), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          rv;
      bit          st;
      bit          dok;
      logic [63:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
      st  = 1'($urandom);
      dok = model_req() && ($urandom_range(0, 4) < 2);
      cyc(rv, rpc, st, dok, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
